// File: rtl/dice_display_scheduler_if.sv
// Digit-pair update channel into the display scheduler.
// The roll logic or the I2C register file acts as master; the scheduler is the slave.
interface dice_display_scheduler_if;
  logic       upd_valid;
  logic       upd_ready;
  logic [3:0] upd_ones;
  logic [3:0] upd_tens;
  logic       upd_lz;

  modport master (
    output upd_valid,
    output upd_ones,
    output upd_tens,
    output upd_lz,
    input  upd_ready
  );

  modport slave (
    input  upd_valid,
    input  upd_ones,
    input  upd_tens,
    input  upd_lz,
    output upd_ready
  );
endinterface

// File: rtl/dice_display_scheduler.sv
// Two-digit 7-segment multiplexer with dead-time blanking, runtime polarity,
// and a one-deep update slot that is committed only at frame boundaries.
//
// state     | meaning
// BLANK_O   | dead time before the ones digit, all segments and commons off
// SHOW_O    | ones digit lit, ones common active
// BLANK_T   | dead time before the tens digit
// SHOW_T    | tens digit lit, tens common active; its last cycle is the commit cycle
module dice_display_scheduler #(
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  dice_display_scheduler_if.slave       upd,
  input  logic                          seg_pol_i,
  input  logic                          com_pol_i,
  output logic [7:0]                    seg_out_o,
  output logic [1:0]                    com_out_o,
  output logic [1:0]                    com_oe_o,
  output logic                          frame_tick_o
);

  localparam int MAX_N = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W = (MAX_N > 1) ? $clog2(MAX_N) : 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {
    S_BLANK_O = 2'd0,
    S_SHOW_O  = 2'd1,
    S_BLANK_T = 2'd2,
    S_SHOW_T  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       lit_q, lit_d;
  logic [1:0]       act_q, act_d;

  logic [3:0]       act_ones_q, act_tens_q;
  logic             act_lz_q;
  logic [3:0]       pend_ones_q, pend_tens_q;
  logic             pend_lz_q;
  logic             pend_full_q;

  logic             last;
  logic             commit;
  logic             accept;

  function automatic logic [6:0] dec(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  assign upd.upd_ready = !rst && !pend_full_q;
  assign accept        = upd.upd_valid && upd.upd_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    last    = 1'b0;
    lit_d   = 8'h00;
    act_d   = 2'b00;
    case (state_q)
      S_BLANK_O: begin
        last = (cnt_q == BLANK_LAST);
        if (last) state_d = S_SHOW_O;
      end
      S_SHOW_O: begin
        last  = (cnt_q == DWELL_LAST);
        lit_d = {1'b0, dec(act_ones_q)};
        act_d = 2'b01;
        if (last) state_d = S_BLANK_T;
      end
      S_BLANK_T: begin
        last = (cnt_q == BLANK_LAST);
        if (last) state_d = S_SHOW_T;
      end
      S_SHOW_T: begin
        last = (cnt_q == DWELL_LAST);
        // common stays driven even when the suppressed leading zero blanks the digit
        lit_d = (act_lz_q && (act_tens_q == 4'd0)) ? 8'h00 : {1'b0, dec(act_tens_q)};
        act_d = 2'b10;
        if (last) state_d = S_BLANK_O;
      end
      default: begin
        state_d = S_BLANK_O;
        last    = 1'b1;
      end
    endcase
    if (last) cnt_d = '0;
  end

  assign commit = (state_q == S_SHOW_T) && last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_BLANK_O;
      cnt_q       <= '0;
      lit_q       <= 8'h00;
      act_q       <= 2'b00;
      act_ones_q  <= 4'hF;
      act_tens_q  <= 4'hF;
      act_lz_q    <= 1'b0;
      pend_ones_q <= 4'hF;
      pend_tens_q <= 4'hF;
      pend_lz_q   <= 1'b0;
      pend_full_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lit_q   <= lit_d;
      act_q   <= act_d;
      // accept needs an empty slot, so it never coincides with a commit that empties one
      if (accept) begin
        pend_ones_q <= upd.upd_ones;
        pend_tens_q <= upd.upd_tens;
        pend_lz_q   <= upd.upd_lz;
        pend_full_q <= 1'b1;
      end else if (commit) begin
        pend_full_q <= 1'b0;
      end
      if (commit && pend_full_q) begin
        act_ones_q <= pend_ones_q;
        act_tens_q <= pend_tens_q;
        act_lz_q   <= pend_lz_q;
      end
    end
  end

  assign seg_out_o    = seg_pol_i ? lit_q : ~lit_q;
  assign com_out_o[0] = act_q[0] ? com_pol_i : ~com_pol_i;
  assign com_out_o[1] = act_q[1] ? com_pol_i : ~com_pol_i;
  assign com_oe_o     = rst ? 2'b00 : 2'b11;
  assign frame_tick_o = commit && !rst;

endmodule

// File: tb/tb_dice_display_scheduler.sv
// Scoreboard bench: accepted pairs queue up as expected frames; a per-cycle
// monitor derives the display timeline from frame position arithmetic.
module tb_dice_display_scheduler;
  localparam int DW    = 4;
  localparam int BL    = 2;
  localparam int FRAME = 2 * (DW + BL);

  typedef struct {
    int ones;
    int tens;
    bit lz;
  } pair_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       seg_pol = 1'b1;
  logic       com_pol = 1'b0;
  logic [7:0] seg_out;
  logic [1:0] com_out;
  logic [1:0] com_oe;
  logic       frame_tick;

  dice_display_scheduler_if upd_if ();

  dice_display_scheduler #(
    .DWELL_CYCLES(DW),
    .BLANK_CYCLES(BL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .upd         (upd_if),
    .seg_pol_i   (seg_pol),
    .com_pol_i   (com_pol),
    .seg_out_o   (seg_out),
    .com_out_o   (com_out),
    .com_oe_o    (com_oe),
    .frame_tick_o(frame_tick)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  logic [6:0] seg_tab [16];
  pair_t      pend_q [$];
  pair_t      act_m;
  bit         m_valid = 1'b0;
  int         m_c = 0;
  logic [7:0] m_lit = 8'h00;
  logic [1:0] m_act = 2'b00;

  int         pos;
  bit         ready_m;
  logic [7:0] e_seg, lit_n;
  logic [1:0] e_com, act_n;
  pair_t      np;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    pos     = m_c % FRAME;
    ready_m = !rst && (pend_q.size() == 0);
    if (m_valid) begin
      e_seg = seg_pol ? m_lit : ~m_lit;
      e_com[0] = m_act[0] ? com_pol : ~com_pol;
      e_com[1] = m_act[1] ? com_pol : ~com_pol;
      chk("com_oe", com_oe, rst ? 0 : 3);
      chk("upd_ready", upd_if.upd_ready, ready_m);
      chk("seg_out", seg_out, e_seg);
      chk("com_out", com_out, e_com);
      chk("frame_tick", frame_tick, (!rst && pos == FRAME - 1));
      chk("both_commons_active", (com_out == {2{com_pol}}), 0);
    end
    if (rst) begin
      pend_q.delete();
      act_m   = '{15, 15, 1'b0};
      m_c     = 0;
      m_lit   = 8'h00;
      m_act   = 2'b00;
      m_valid = 1'b1;
    end else if (m_valid) begin
      lit_n = 8'h00;
      act_n = 2'b00;
      if (pos >= BL && pos < BL + DW) begin
        lit_n = {1'b0, seg_tab[act_m.ones]};
        act_n = 2'b01;
      end else if (pos >= 2 * BL + DW) begin
        lit_n = (act_m.lz && act_m.tens == 0) ? 8'h00 : {1'b0, seg_tab[act_m.tens]};
        act_n = 2'b10;
      end
      if (pos == FRAME - 1 && pend_q.size() != 0) act_m = pend_q.pop_front();
      if (upd_if.upd_valid && ready_m) begin
        np = '{int'(upd_if.upd_ones), int'(upd_if.upd_tens), upd_if.upd_lz};
        pend_q.push_back(np);
      end
      m_lit = lit_n;
      m_act = act_n;
      m_c++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic offer(input int o, input int t, input bit lz);
    int  n;
    bit  acc;
    n   = 0;
    acc = 1'b0;
    upd_if.upd_valid = 1'b1;
    upd_if.upd_ones  = 4'(o);
    upd_if.upd_tens  = 4'(t);
    upd_if.upd_lz    = lz;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = upd_if.upd_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL offer_timeout at %0t: got=ready_low expected=accept", $time);
    end
    upd_if.upd_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog at %0t: got=running expected=finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
    act_m = '{15, 15, 1'b0};
    upd_if.upd_valid = 1'b0;
    upd_if.upd_ones  = 4'd0;
    upd_if.upd_tens  = 4'd0;
    upd_if.upd_lz    = 1'b0;

    idle(3);
    rst = 1'b0;
    idle(30);

    offer(2, 4, 1'b0);
    idle(30);

    offer(3, 1, 1'b0);
    offer(7, 0, 1'b1);
    idle(30);

    offer(8, 8, 1'b0);
    idle(14);
    repeat (24) begin
      seg_pol = 1'($urandom_range(0, 1));
      com_pol = 1'($urandom_range(0, 1));
      idle(1);
    end
    seg_pol = 1'b1;
    com_pol = 1'b0;
    idle(4);

    offer(12, 15, 1'b0);
    idle(30);

    offer(5, 6, 1'b0);
    offer(1, 2, 1'b0);
    n = 0;
    while (((m_c % FRAME) < 2 * BL + DW) && n < 50) begin
      idle(1);
      n++;
    end
    chk("pending_before_reset", pend_q.size(), 1);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(30);

    repeat (40) begin
      idle($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) begin
        seg_pol = 1'($urandom_range(0, 1));
        com_pol = 1'($urandom_range(0, 1));
      end
      offer($urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom_range(0, 1)));
    end
    idle(30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dice_display_scheduler.md
# dice_display_scheduler

Time-multiplexing controller for the two-digit 7-segment display of the dice roller. Shares the single segment bus (`uo_out`) between the ones and tens digit commons (`uio_out[0]`, `uio_out[1]`). Inserts dead-time blanking between digits and applies runtime segment/common polarity. Accepts new digit pairs from the roll logic or the I2C register file through a valid/ready handshake, and commits them only at frame boundaries so the display never tears.

## Interface
- `DWELL_CYCLES`, default 1000: clock cycles each digit is lit per frame; legal values are 1 and above.
- `BLANK_CYCLES`, default 16: dead-time cycles before each digit, with all segments unlit and both commons inactive; legal values are 1 and above.
- `clk` in, 1 bit: system clock.
- `rst` in, 1 bit: reset, synchronous, active-high.
- `upd_valid` in, 1 bit: new digit pair offered.
- `upd_ready` out, 1 bit: pending slot empty and not in reset.
- `upd_ones` in, 4 bits: ones value. 0–9 are shown; 10–15 blank the digit.
- `upd_tens` in, 4 bits: tens value, same encoding as `upd_ones`.
- `upd_lz` in, 1 bit: leading-zero suppression. When set, `upd_tens==0` is shown blank.
- `seg_pol` in, 1 bit: segment active level (1 means a lit segment drives 1).
- `com_pol` in, 1 bit: common active level.
- `seg_out` out, 8 bits: segments {dp,g,f,e,d,c,b,a}.
- `com_out` out, 2 bits: [0] ones common, [1] tens common.
- `com_oe` out, 2 bits: common output enables.
- `frame_tick` out, 1 bit: one-cycle pulse on each frame boundary, which is also the commit cycle.

## Operation
- Internal registers:
  - `lit[7:0]`: segments to light.
  - `act[1:0]`: which common is active.
  - Active pair (ones, tens, lz).
  - Pending pair plus `pend_full`.
  - `cnt`: width clog2(max(DWELL,BLANK)).
  - `state`.
- Outputs:
  - `seg_out = seg_pol ? lit : ~lit`.
  - `com_out[i] = act[i] ? com_pol : ~com_pol`.
  - `com_oe = 2'b11` whenever `rst` is 0.
- FSM states: BLANK_O → SHOW_O → BLANK_T → SHOW_T → BLANK_O.
  - BLANK states last BLANK_CYCLES; SHOW states last DWELL_CYCLES.
  - `cnt` runs 0..N-1, then resets to 0 and the state advances.
- Per state:
  - BLANK_*: `lit=0`, `act=00`.
  - SHOW_O: `lit=dec(ones)`, `act=01`.
  - SHOW_T: `lit=dec(tens)`, `act=10`, with `lit=0` if `lz && tens==0`. The common stays active even when the digit is blank.
- Decoder `dec`, output {g..a}, with dp always 0:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - 10–15 decode to 00.
- Handshake:
  - `upd_ready = !rst && !pend_full`.
  - When `upd_valid && upd_ready`, the pending pair is loaded and `pend_full` is set.
  - Data offered while `upd_ready` is 0 is not captured; `upd_valid` must be held.
- Commit happens on the SHOW_T→BLANK_O transition cycle, which is also when `frame_tick`=1:
  - If `pend_full`: active ← pending, `pend_full` ← 0.
  - A handshake cannot occur on the same cycle a commit clears `pend_full` (ready was 0), so there is no conflict.
  - A capture on the commit cycle when `pend_full` was already 0 loads pending and waits for the next frame.
- Only the most recent accepted pair is shown. At most one pair is pending; the upstream is throttled by `upd_ready`.

## Timing
- Reset values, applied on the first `clk` edge with `rst`=1:
  - `state`=BLANK_O, `cnt`=0, `lit`=0, `act`=00, `frame_tick`=0.
  - Active pair = (F, F, 0), so the display is blank.
  - `pend_full`=0.
  - While `rst` is high: `com_oe`=00, `upd_ready`=0.
- Reset asserted mid-frame or mid-handshake discards the pending and active pairs. There is no partial commit.
- Frame length is 2·(BLANK_CYCLES+DWELL_CYCLES) cycles.
- Ones digit:
  - First lit cycle is BLANK_CYCLES after `rst` deasserts.
  - `lit` and `act` are registered, so outputs change one clock after the state change. This is consistent for all states.
- Update latency: from acceptance to the ones digit showing new data is at most one frame + BLANK_CYCLES + 1.
- `seg_pol` and `com_pol` changes affect the outputs combinationally in the same cycle.
- `act` never has both bits set. There is never a cycle where one common turns off and the other turns on; at least BLANK_CYCLES separate them.

## Test plan
All scenarios use DWELL_CYCLES=4 and BLANK_CYCLES=2, giving a 12-cycle frame.

1. Reset, then idle with `seg_pol`=1 and `com_pol`=0:
   - `seg_out`=00 always.
   - `com_out` alternates: 11 for 2 cycles, 10 for 4, 11 for 2, 01 for 4.
   - `frame_tick` pulses every 12 cycles.
2. Offer (tens=4, ones=2, lz=0):
   - `upd_ready` drops the cycle after capture.
   - On the next frame, ones shows 5B and tens shows 66.
   - `upd_ready` returns to 1 the cycle after `frame_tick`.
3. Offer two pairs back-to-back, (1,3) then (0,7) with lz=1:
   - The second is held off until the commit.
   - Frame n shows 4F on ones and 06 on tens.
   - Frame n+1 shows 07 on ones, with tens `seg_out`=00 while the tens common is still active.
4. Polarity sweep on a displayed 8, toggling `seg_pol` and `com_pol`:
   - `seg_out` flips between 7F and 80.
   - Active/inactive common levels invert in the same cycle.
5. Values 12 and 15 offered: both digits are blank (`seg_out`=00 with `seg_pol`=1).
6. Reset asserted mid-SHOW_T with a pair pending:
   - Next cycle: `com_oe`=00 and `lit`=0.
   - After release, the display stays blank until a new pair is accepted.
   - Check throughout that `act`=11 never occurs.
